// File: rtl/ramb16_arb_pkg.sv
// Shared types and default widths for the two-requester RAMB16_S4 arbiter.
package ramb16_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } owner_t;

    typedef enum logic {
        ID_A,
        ID_B
    } req_id_t;

endpackage

// File: rtl/rr_burst_sel.sv
// Round-robin grant decision with a burst limit; owns the owner/last/cnt registers.
module rr_burst_sel
    import ramb16_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    owner_t  owner, owner_nxt;
    req_id_t last, last_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic a_win, b_win;

    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        case (owner)
            OWN_A: begin
                if (a_req && (!b_req || cnt < MAX_CNT)) a_win = 1'b1;
                else if (b_req)                          b_win = 1'b1;
            end
            OWN_B: begin
                if (b_req && (!a_req || cnt < MAX_CNT)) b_win = 1'b1;
                else if (a_req)                          a_win = 1'b1;
            end
            default: begin
                // On a tie from idle, whoever did not own the port last time goes first.
                if (a_req && b_req) begin
                    a_win = (last == ID_B);
                    b_win = (last == ID_A);
                end else begin
                    a_win = a_req;
                    b_win = b_req;
                end
            end
        endcase
    end

    // No access may reach the RAM while reset is held, even with requests pending.
    assign a_gnt = a_win & ~rst;
    assign b_gnt = b_win & ~rst;

    always_comb begin
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        if (a_win) begin
            if (owner == OWN_A) begin
                cnt_nxt = (cnt < MAX_CNT) ? cnt + 4'd1 : cnt;
            end else begin
                owner_nxt = OWN_A;
                cnt_nxt   = 4'd1;
            end
        end else if (b_win) begin
            if (owner == OWN_B) begin
                cnt_nxt = (cnt < MAX_CNT) ? cnt + 4'd1 : cnt;
            end else begin
                owner_nxt = OWN_B;
                cnt_nxt   = 4'd1;
            end
        end else begin
            owner_nxt = IDLE;
            cnt_nxt   = 4'd0;
            if (owner == OWN_A)      last_nxt = ID_A;
            else if (owner == OWN_B) last_nxt = ID_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= IDLE;
            last  <= ID_B;
            cnt   <= 4'd0;
        end else begin
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ramb16_s4_arbiter.sv
// Shares one single-port 4096x4 block RAM between two requesters, one access per clock,
// and steers registered read data back to whichever requester issued the read.
module ramb16_s4_arbiter
    import ramb16_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DI,
    output logic              A_GNT,
    output logic              A_VLD,
    output logic [DATA_W-1:0] A_DO,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DI,
    output logic              B_GNT,
    output logic              B_VLD,
    output logic [DATA_W-1:0] B_DO,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO
);

    rr_burst_sel #(
        .MAX_BURST(MAX_BURST)
    ) u_sel (
        .clk  (CLK),
        .rst  (RST),
        .a_req(A_REQ),
        .b_req(B_REQ),
        .a_gnt(A_GNT),
        .b_gnt(B_GNT)
    );

    always_comb begin
        RAM_EN   = A_GNT | B_GNT;
        RAM_WE   = 1'b0;
        RAM_ADDR = '0;
        RAM_DI   = '0;
        if (A_GNT) begin
            RAM_WE   = A_WE;
            RAM_ADDR = A_ADDR;
            RAM_DI   = A_DI;
        end else if (B_GNT) begin
            RAM_WE   = B_WE;
            RAM_ADDR = B_ADDR;
            RAM_DI   = B_DI;
        end
    end

    // The RAM output register lands one cycle after the grant, so the valid strobe tracks it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A_VLD <= 1'b0;
            B_VLD <= 1'b0;
        end else begin
            A_VLD <= A_GNT & ~A_WE;
            B_VLD <= B_GNT & ~B_WE;
        end
    end

    assign A_DO = A_VLD ? RAM_DO : '0;
    assign B_DO = B_VLD ? RAM_DO : '0;

endmodule

// File: tb/tb_ramb16_s4_arbiter.sv
// Directed self-checking bench for ramb16_s4_arbiter with a behavioural write-first RAM.
module tb_ramb16_s4_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        A_REQ = 1'b0, A_WE = 1'b0;
    logic [11:0] A_ADDR = '0;
    logic [3:0]  A_DI = '0;
    logic        A_GNT, A_VLD;
    logic [3:0]  A_DO;
    logic        B_REQ = 1'b0, B_WE = 1'b0;
    logic [11:0] B_ADDR = '0;
    logic [3:0]  B_DI = '0;
    logic        B_GNT, B_VLD;
    logic [3:0]  B_DO;
    logic        RAM_EN, RAM_WE;
    logic [11:0] RAM_ADDR;
    logic [3:0]  RAM_DI;
    logic [3:0]  RAM_DO;

    logic [3:0]  mem [0:4095];
    int tests_run = 0;
    int tests_failed = 0;

    ramb16_s4_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI),
        .A_GNT(A_GNT), .A_VLD(A_VLD), .A_DO(A_DO),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI),
        .B_GNT(B_GNT), .B_VLD(B_VLD), .B_DO(B_DO),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    always #5 CLK = ~CLK;

    // RAMB16_S4 in WRITE_FIRST mode: a write also presents the written data on DO.
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) begin
                mem[RAM_ADDR] <= RAM_DI;
                RAM_DO        <= RAM_DI;
            end else begin
                RAM_DO <= mem[RAM_ADDR];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ar, input logic aw, input logic [11:0] aa, input logic [3:0] ad,
                                 input logic br, input logic bw, input logic [11:0] ba, input logic [3:0] bd);
        A_REQ = ar; A_WE = aw; A_ADDR = aa; A_DI = ad;
        B_REQ = br; B_WE = bw; B_ADDR = ba; B_DI = bd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b1;
        applyStimulus(0, 0, 12'h0, 4'h0, 0, 0, 12'h0, 4'h0);
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic exp_a, prev_a, prev_b;
        for (int i = 0; i < 4096; i++) mem[i] = 4'(i);
        RAM_DO = 4'h0;

        // Reset with both requesters asking: nothing may reach the RAM.
        tick();
        RST = 1'b1;
        applyStimulus(1, 0, 12'h010, 4'h0, 1, 0, 12'h011, 4'h0);
        #1;
        checkOutput("rst a_gnt", A_GNT, 0);
        checkOutput("rst b_gnt", B_GNT, 0);
        checkOutput("rst a_vld", A_VLD, 0);
        checkOutput("rst b_vld", B_VLD, 0);
        checkOutput("rst a_do", A_DO, 0);
        checkOutput("rst b_do", B_DO, 0);
        checkOutput("rst ram_en", RAM_EN, 0);
        tick();
        RST = 1'b0;
        #1;
        checkOutput("post-rst a_gnt", A_GNT, 1);
        checkOutput("post-rst b_gnt", B_GNT, 0);

        // A writes 0xA to 0x123 then reads it back.
        doReset();
        applyStimulus(1, 1, 12'h123, 4'hA, 0, 0, 12'h0, 4'h0);
        #1;
        checkOutput("wr a_gnt", A_GNT, 1);
        checkOutput("wr ram_en", RAM_EN, 1);
        checkOutput("wr ram_we", RAM_WE, 1);
        checkOutput("wr ram_addr", RAM_ADDR, 12'h123);
        checkOutput("wr ram_di", RAM_DI, 4'hA);
        tick();
        applyStimulus(1, 0, 12'h123, 4'h0, 0, 0, 12'h0, 4'h0);
        #1;
        checkOutput("rd a_gnt", A_GNT, 1);
        checkOutput("rd ram_we", RAM_WE, 0);
        checkOutput("wr no a_vld", A_VLD, 0);
        tick();
        applyStimulus(0, 0, 12'h0, 4'h0, 0, 0, 12'h0, 4'h0);
        #1;
        checkOutput("rd a_vld", A_VLD, 1);
        checkOutput("rd a_do", A_DO, 4'hA);
        checkOutput("rd b_vld", B_VLD, 0);
        checkOutput("idle ram_en", RAM_EN, 0);
        tick();

        // Both read continuously: expect AAAABBBBAAAA.
        doReset();
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 12'h123, 4'h0, 1, 0, 12'h124, 4'h0);
            #1;
            exp_a = ((i % 8) < 4);
            checkOutput($sformatf("burst%0d a_gnt", i), A_GNT, exp_a);
            checkOutput($sformatf("burst%0d b_gnt", i), B_GNT, !exp_a);
            checkOutput($sformatf("burst%0d a_vld", i), A_VLD, prev_a);
            checkOutput($sformatf("burst%0d b_vld", i), B_VLD, prev_b);
            checkOutput($sformatf("burst%0d a_do", i), A_DO, prev_a ? 4'hA : 4'h0);
            checkOutput($sformatf("burst%0d b_do", i), B_DO, prev_b ? 4'h4 : 4'h0);
            tick();
            prev_a = exp_a;
            prev_b = !exp_a;
        end

        // Only B requests for 10 cycles: granted every cycle.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 12'h0, 4'h0, 1, 0, 12'h124, 4'h0);
            #1;
            checkOutput($sformatf("bonly%0d b_gnt", i), B_GNT, 1);
            checkOutput($sformatf("bonly%0d a_gnt", i), A_GNT, 0);
            checkOutput($sformatf("bonly%0d b_vld", i), B_VLD, (i > 0) ? 1 : 0);
            tick();
        end

        // Address extremes: no aliasing between 0xFFF and 0x000.
        doReset();
        applyStimulus(1, 1, 12'hFFF, 4'h5, 0, 0, 12'h0, 4'h0);
        #1;
        checkOutput("edge a_wr gnt", A_GNT, 1);
        tick();
        applyStimulus(0, 0, 12'h0, 4'h0, 1, 1, 12'h000, 4'h3);
        #1;
        checkOutput("edge b_wr gnt", B_GNT, 1);
        checkOutput("edge b_wr addr", RAM_ADDR, 12'h000);
        tick();
        applyStimulus(1, 0, 12'hFFF, 4'h0, 0, 0, 12'h0, 4'h0);
        #1;
        checkOutput("edge a_rd gnt", A_GNT, 1);
        checkOutput("edge a_rd addr", RAM_ADDR, 12'hFFF);
        tick();
        applyStimulus(0, 0, 12'h0, 4'h0, 1, 0, 12'hFFF, 4'h0);
        #1;
        checkOutput("edge b_rd gnt", B_GNT, 1);
        checkOutput("edge a_vld", A_VLD, 1);
        checkOutput("edge a_do", A_DO, 4'h5);
        tick();
        applyStimulus(0, 0, 12'h0, 4'h0, 0, 0, 12'h0, 4'h0);
        #1;
        checkOutput("edge b_vld", B_VLD, 1);
        checkOutput("edge b_do", B_DO, 4'h5);
        checkOutput("edge a_vld off", A_VLD, 0);
        tick();

        // Reset pulse the cycle after a read grant drops the pending VLD and clears the burst count.
        doReset();
        applyStimulus(1, 0, 12'h123, 4'h0, 1, 0, 12'h124, 4'h0);
        #1;
        checkOutput("mid a_gnt", A_GNT, 1);
        tick();
        RST = 1'b1;
        #1;
        checkOutput("mid rst a_vld", A_VLD, 0);
        checkOutput("mid rst a_do", A_DO, 0);
        checkOutput("mid rst a_gnt", A_GNT, 0);
        checkOutput("mid rst ram_en", RAM_EN, 0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("after%0d a_gnt", i), A_GNT, (i < 4) ? 1 : 0);
            checkOutput($sformatf("after%0d b_gnt", i), B_GNT, (i < 4) ? 0 : 1);
            tick();
        end
        applyStimulus(0, 0, 12'h0, 4'h0, 0, 0, 12'h0, 4'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
